// File: rtl/square_pkg.sv
// Shared arithmetic definitions for the squarer and its square-root partner.
// Both units use the same state encoding, so busy==0 means "ready" on either.
package square_pkg;

  // Default operand width in bits.
  localparam int IN_W_DEF = 5;

  // FSM state encoding shared with the root unit; 2'h3 is unused.
  typedef enum logic [1:0] {
    IDLE       = 2'h0,
    ADD_STEP   = 2'h1,
    SHIFT_STEP = 2'h2
  } state_t;

  // Result width of a squarer with an in_w-bit operand.
  function automatic int res_w(input int in_w);
    return 2 * in_w;
  endfunction

endpackage

// File: rtl/square.sv
// Multi-cycle unsigned squarer: y = x*x by shift-and-add, one multiplier bit
// per ADD/SHIFT step pair. Latency is fixed at 2*IN_W+1 cycles after the
// accepting edge, with no early exit, so the result timing never depends on x.
module square
  import square_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [IN_W-1:0]        x_bi,
  output logic [res_w(IN_W)-1:0] y_bo,
  output logic [1:0]             busy_o
);

  localparam int OUT_W = res_w(IN_W);
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t             state_reg, state_next;
  logic [OUT_W-1:0]   a_reg, a_next;      // shifted multiplicand
  logic [IN_W-1:0]    m_reg, m_next;      // remaining multiplier bits
  logic [OUT_W-1:0]   acc_reg, acc_next;  // partial product sum
  logic [CNT_W-1:0]   cnt_reg, cnt_next;  // multiplier bits left to process
  logic [OUT_W-1:0]   y_reg, y_next;      // published result

  // Next-state and datapath update; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    m_next     = m_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          a_next     = OUT_W'(x_bi);
          m_next     = x_bi;
          acc_next   = '0;
          cnt_next   = CNT_W'(IN_W);
          state_next = ADD_STEP;
        end
      end
      ADD_STEP: begin
        if (cnt_reg != '0) begin
          if (m_reg[0]) begin
            acc_next = acc_reg + a_reg;
          end
          state_next = SHIFT_STEP;
        end else begin
          // Only place the result is written, so aborted runs never leak out.
          y_next     = acc_reg;
          state_next = IDLE;
        end
      end
      SHIFT_STEP: begin
        a_next     = a_reg << 1;
        m_next     = m_reg >> 1;
        cnt_next   = cnt_reg - 1'b1;
        state_next = ADD_STEP;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; only control, accumulator and result reset.
  always_ff @(posedge clk_i) begin
    a_reg   <= a_next;
    m_reg   <= m_next;
    cnt_reg <= cnt_next;
    if (rst_i) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      y_reg     <= y_next;
    end
  end

  assign y_bo   = y_reg;
  assign busy_o = state_reg;

endmodule

// File: tb/tb_square.sv
// Self-checking bench for square: directed sequence with a queue scoreboard,
// latency/hold checks and a square-root round-trip model.
module tb_square;
  import square_pkg::*;

  localparam int W   = IN_W_DEF;
  localparam int OUT = res_w(W);
  localparam int LAT = 2 * W + 1;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [W-1:0]   x_bi;
  logic [OUT-1:0] y_bo;
  logic [1:0]     busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  square #(.IN_W(W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .x_bi   (x_bi),
    .y_bo   (y_bo),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Integer square root model standing in for the root unit.
  function automatic logic [31:0] isqrt(input logic [31:0] v);
    logic [31:0] r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Start one operation (accepted at the next edge), optionally poke a
  // competing start at edge E0+poke_at, then check latency, hold and result.
  task automatic run_op(input logic [W-1:0] xv, input int poke_at, input bit round_trip);
    int          c;
    logic [31:0] hold;
    logic [31:0] e;
    logic [31:0] xe;
    start_i = 1'b1;
    x_bi    = xv;
    tick();
    xe = 32'(xv);
    exp_q.push_back(xe * xe);
    start_i = 1'b0;
    x_bi    = W'($urandom);
    hold    = 32'(y_bo);
    c       = 0;
    while (busy_o != 2'd0 && c < 40) begin
      if (32'(y_bo) !== hold) check("hold", 32'(y_bo), hold);
      if (poke_at > 0 && c == poke_at - 1) begin
        start_i = 1'b1;
        x_bi    = W'(3);
      end else if (poke_at > 0 && c == poke_at) begin
        start_i = 1'b0;
      end
      tick();
      c++;
    end
    e = exp_q.pop_front();
    check("latency", 32'(c), 32'(LAT));
    check("result", 32'(y_bo), e);
    check("idle", 32'(busy_o), 32'd0);
    if (round_trip) check("roundtrip", isqrt(32'(y_bo)), xe);
    $display("op x=%0d y=%0d busy_cycles=%0d", xv, y_bo, c);
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    x_bi    = '0;
    tick();
    tick();
    rst_i = 1'b0;
    check("reset_y", 32'(y_bo), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    $display("reset y=%0d busy=%0d", y_bo, busy_o);

    // Basic directed values.
    run_op(W'(0), 0, 1'b0);
    run_op(W'(5), 0, 1'b0);
    run_op(W'(31), 0, 1'b0);

    // Exhaustive back-to-back, each started in the first idle cycle.
    for (int i = 0; i < (1 << W); i++) begin
      run_op(W'(i), 0, 1'b1);
    end

    // Start while busy must be ignored; next result unaffected.
    run_op(W'(7), 4, 1'b0);
    check("no_queue", 32'(busy_o), 32'd0);
    tick();
    check("still_idle", 32'(busy_o), 32'd0);
    run_op(W'(3), 0, 1'b0);

    // Reset mid-operation aborts with no later write.
    start_i = 1'b1;
    x_bi    = W'(31);
    tick();
    exp_q.push_back(32'd961);
    start_i = 1'b0;
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    void'(exp_q.pop_front());
    check("abort_y", 32'(y_bo), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    $display("abort y=%0d busy=%0d", y_bo, busy_o);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (y_bo !== '0 || busy_o !== 2'd0) check("abort_quiet", 32'(y_bo), 32'd0);
    end
    check("abort_final", 32'(y_bo), 32'd0);

    // Recovery after abort.
    run_op(W'(31), 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
